// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: deserializes and validates 48-bit command
// frames, presents them in parallel, and serializes an R1-style response.
module sd_cmd_responder #(
   parameter int NCR = 2
) (
   input  logic        CLK_SD_card,
   input  logic        reset,
   input  logic        cmd_to_sd,
   input  logic [31:0] response_status,
   output logic        cmd_from_sd,
   output logic        cmd_from_sd_oe,
   output logic [5:0]  received_index,
   output logic [31:0] received_arg,
   output logic        cmd_valid,
   output logic        crc_error
);

   typedef enum logic [2:0] {S_IDLE, S_RECEIVE, S_CHECK, S_WAIT, S_SEND} state_t;

   localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   state_t      state;
   logic [5:0]  cnt;
   logic [47:0] rx_sr;
   logic [47:0] tx_sr;

   logic [39:0] rsp_hdr;
   logic [47:0] rsp_word;
   logic        frame_ok;

   // Status is taken straight from the port so it is captured on the SEND entry edge.
   assign rsp_hdr  = {2'b00, received_index, response_status};
   assign rsp_word = {rsp_hdr, crc7(rsp_hdr), 1'b1};
   assign frame_ok = !rx_sr[47] && rx_sr[46] && rx_sr[0] &&
                     (crc7(rx_sr[47:8]) == rx_sr[7:1]);

   always_ff @(posedge CLK_SD_card) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         rx_sr          <= '0;
         tx_sr          <= '0;
         cmd_from_sd    <= 1'b1;
         cmd_from_sd_oe <= 1'b0;
         received_index <= '0;
         received_arg   <= '0;
         cmd_valid      <= 1'b0;
         crc_error      <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         crc_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!cmd_to_sd) begin
                  rx_sr <= '0;
                  cnt   <= 6'd1;
                  state <= S_RECEIVE;
               end
            end
            S_RECEIVE: begin
               rx_sr <= {rx_sr[46:0], cmd_to_sd};
               cnt   <= cnt + 6'd1;
               if (cnt == 6'd47) state <= S_CHECK;
            end
            S_CHECK: begin
               cnt <= '0;
               if (frame_ok) begin
                  cmd_valid      <= 1'b1;
                  received_index <= rx_sr[45:40];
                  received_arg   <= rx_sr[39:8];
                  // CMD0 is accepted silently
                  state          <= (rx_sr[45:40] != 6'd0) ? S_WAIT : S_IDLE;
               end else begin
                  crc_error <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (cnt == NCR_LAST) begin
                  cmd_from_sd_oe <= 1'b1;
                  cmd_from_sd    <= rsp_word[47];
                  tx_sr          <= {rsp_word[46:0], 1'b0};
                  cnt            <= 6'd1;
                  state          <= S_SEND;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_SEND: begin
               if (cnt == 6'd48) begin
                  cmd_from_sd_oe <= 1'b0;
                  cmd_from_sd    <= 1'b1;
                  cnt            <= '0;
                  state          <= S_IDLE;
               end else begin
                  cmd_from_sd <= tx_sr[47];
                  tx_sr       <= {tx_sr[46:0], 1'b0};
                  cnt         <= cnt + 6'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: drives serial frames, scoreboards the serial
// responses captured by a line monitor.
module tb_sd_cmd_responder;
   localparam int NCR = 2;

   logic        CLK_SD_card = 1'b0;
   logic        reset;
   logic        cmd_to_sd;
   logic [31:0] response_status;
   logic        cmd_from_sd;
   logic        cmd_from_sd_oe;
   logic [5:0]  received_index;
   logic [31:0] received_arg;
   logic        cmd_valid;
   logic        crc_error;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int c0 = 0;

   logic [47:0] got_word[$];
   int          got_len[$];
   int          got_rise[$];
   logic [47:0] exp_word[$];
   int          exp_rise[$];

   logic [47:0] mon_word = '0;
   int          mon_len = 0;
   int          mon_rise = 0;
   logic        oe_q = 1'b0;

   sd_cmd_responder #(.NCR(NCR)) dut (
      .CLK_SD_card    (CLK_SD_card),
      .reset          (reset),
      .cmd_to_sd      (cmd_to_sd),
      .response_status(response_status),
      .cmd_from_sd    (cmd_from_sd),
      .cmd_from_sd_oe (cmd_from_sd_oe),
      .received_index (received_index),
      .received_arg   (received_arg),
      .cmd_valid      (cmd_valid),
      .crc_error      (crc_error)
   );

   always #5 CLK_SD_card = ~CLK_SD_card;
   always @(posedge CLK_SD_card) cyc <= cyc + 1;

   // Line monitor: collects each driven response burst and counts pulses.
   always @(negedge CLK_SD_card) begin
      if (cmd_from_sd_oe === 1'b1) begin
         if (!oe_q) begin
            mon_word = '0;
            mon_len  = 0;
            mon_rise = cyc;
         end
         mon_word = {mon_word[46:0], cmd_from_sd};
         mon_len++;
      end else if (oe_q) begin
         got_word.push_back(mon_word);
         got_len.push_back(mon_len);
         got_rise.push_back(mon_rise);
      end
      oe_q = (cmd_from_sd_oe === 1'b1);
      if (cmd_valid === 1'b1) n_valid++;
      if (crc_error === 1'b1) n_err++;
   end

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         if (c[6] ^ d[i]) c = {c[5:0], 1'b0} ^ 7'h09;
         else             c = {c[5:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_frame(input logic [39:0] hdr);
      return {hdr, crc7(hdr), 1'b1};
   endfunction

   // Caller is at a negedge; bit 47 goes out now. Returns at the negedge after the end-bit edge.
   task automatic send_frame(input logic [47:0] f);
      cmd_to_sd = f[47];
      for (int i = 46; i >= 0; i--) begin
         @(negedge CLK_SD_card);
         cmd_to_sd = f[i];
      end
      @(negedge CLK_SD_card);
      cmd_to_sd = 1'b1;
      c0 = cyc;
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge CLK_SD_card);
         ok = (got_word.size() != 0);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rsp_timeout: got no response in 200 cycles, need one");
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cmd_to_sd = 1'b1;
      response_status = '0;
      repeat (3) @(negedge CLK_SD_card);
      checks += 6;
      if (cmd_from_sd !== 1'b1)    begin errors++; $display("FAIL rst_cmd: got %b need 1", cmd_from_sd); end
      if (cmd_from_sd_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b need 0", cmd_from_sd_oe); end
      if (received_index !== 6'd0) begin errors++; $display("FAIL rst_idx: got %h need 0", received_index); end
      if (received_arg !== 32'd0)  begin errors++; $display("FAIL rst_arg: got %h need 0", received_arg); end
      if (cmd_valid !== 1'b0)      begin errors++; $display("FAIL rst_valid: got %b need 0", cmd_valid); end
      if (crc_error !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b need 0", crc_error); end
      reset = 1'b1;
   endtask

   task automatic test_cmd0();
      int v0;
      v0 = n_valid;
      @(negedge CLK_SD_card);
      send_frame(48'h40_0000_0000_95);
      @(negedge CLK_SD_card);
      checks += 4;
      if (cmd_valid !== 1'b1)      begin errors++; $display("FAIL cmd0_valid: got %b need 1", cmd_valid); end
      if (crc_error !== 1'b0)      begin errors++; $display("FAIL cmd0_err: got %b need 0", crc_error); end
      if (received_index !== 6'd0) begin errors++; $display("FAIL cmd0_idx: got %h need 0", received_index); end
      if (received_arg !== 32'd0)  begin errors++; $display("FAIL cmd0_arg: got %h need 0", received_arg); end
      @(negedge CLK_SD_card);
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd0_pulse: got %b need 0", cmd_valid); end
      repeat (60) @(negedge CLK_SD_card);
      checks += 2;
      if (got_word.size() != 0) begin errors++; $display("FAIL cmd0_norsp: got %0d responses need 0", got_word.size()); end
      if (n_valid - v0 != 1)    begin errors++; $display("FAIL cmd0_count: got %0d pulses need 1", n_valid - v0); end
   endtask

   task automatic test_cmd17();
      bit ok;
      logic [47:0] w, ew;
      int l, r, er;
      response_status = 32'h0000_0900;
      @(negedge CLK_SD_card);
      send_frame(48'h51_0000_0000_55);
      exp_word.push_back(mk_frame({2'b00, 6'd17, 32'h0000_0900}));
      exp_rise.push_back(c0 + 1 + NCR);
      @(negedge CLK_SD_card);
      checks += 3;
      if (cmd_valid !== 1'b1)       begin errors++; $display("FAIL cmd17_valid: got %b need 1", cmd_valid); end
      if (received_index !== 6'd17) begin errors++; $display("FAIL cmd17_idx: got %0d need 17", received_index); end
      if (received_arg !== 32'd0)   begin errors++; $display("FAIL cmd17_arg: got %h need 0", received_arg); end
      repeat (NCR) @(negedge CLK_SD_card);
      response_status = 32'hDEAD_BEEF;
      wait_rsp(ok);
      ew = exp_word.pop_front();
      er = exp_rise.pop_front();
      if (ok) begin
         w = got_word.pop_front(); l = got_len.pop_front(); r = got_rise.pop_front();
         checks += 5;
         if (w !== ew)                  begin errors++; $display("FAIL cmd17_rsp: got %h need %h", w, ew); end
         if (w[47:8] !== 40'h11_0000_0900) begin errors++; $display("FAIL cmd17_hdr: got %h need 1100000900", w[47:8]); end
         if (w[0] !== 1'b1)             begin errors++; $display("FAIL cmd17_end: got %b need 1", w[0]); end
         if (l != 48)                   begin errors++; $display("FAIL cmd17_len: got %0d need 48", l); end
         if (r != er)                   begin errors++; $display("FAIL cmd17_lat: oe rose at %0d need %0d", r, er); end
      end
   endtask

   task automatic test_crc_error();
      @(negedge CLK_SD_card);
      send_frame(48'h48_0000_01AA_87 ^ 48'h2);
      @(negedge CLK_SD_card);
      checks += 4;
      if (crc_error !== 1'b1)       begin errors++; $display("FAIL crc_err: got %b need 1", crc_error); end
      if (cmd_valid !== 1'b0)       begin errors++; $display("FAIL crc_valid: got %b need 0", cmd_valid); end
      if (received_arg !== 32'd0)   begin errors++; $display("FAIL crc_arg: got %h need 0", received_arg); end
      if (received_index !== 6'd17) begin errors++; $display("FAIL crc_idx: got %0d need 17", received_index); end
      @(negedge CLK_SD_card);
      checks++;
      if (crc_error !== 1'b0) begin errors++; $display("FAIL crc_pulse: got %b need 0", crc_error); end
      repeat (60) @(negedge CLK_SD_card);
      checks++;
      if (got_word.size() != 0) begin errors++; $display("FAIL crc_norsp: got %0d responses need 0", got_word.size()); end
   endtask

   // Second frame starts one cycle after the first is rejected.
   task automatic test_bad_bits();
      logic [47:0] f [2];
      f[0] = mk_frame(40'h08_0000_01AA);
      f[1] = {40'h48_0000_01AA, 7'h43, 1'b0};
      @(negedge CLK_SD_card);
      for (int k = 0; k < 2; k++) begin
         send_frame(f[k]);
         @(negedge CLK_SD_card);
         checks += 2;
         if (crc_error !== 1'b1) begin errors++; $display("FAIL bad%0d_err: got %b need 1", k, crc_error); end
         if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bad%0d_valid: got %b need 0", k, cmd_valid); end
      end
      repeat (60) @(negedge CLK_SD_card);
      checks++;
      if (got_word.size() != 0) begin errors++; $display("FAIL bad_norsp: got %0d responses need 0", got_word.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [47:0] f, w, ew;
      int l, r, er;
      f = 48'h51_0000_0000_55;
      @(negedge CLK_SD_card);
      cmd_to_sd = f[47];
      for (int i = 46; i >= 20; i--) begin
         @(negedge CLK_SD_card);
         cmd_to_sd = f[i];
      end
      reset = 1'b0;
      @(negedge CLK_SD_card);
      reset = 1'b1;
      cmd_to_sd = 1'b1;
      checks += 4;
      if (cmd_from_sd !== 1'b1 || cmd_from_sd_oe !== 1'b0) begin errors++; $display("FAIL rx_rst_line: got cmd=%b oe=%b need 1/0", cmd_from_sd, cmd_from_sd_oe); end
      if (received_index !== 6'd0) begin errors++; $display("FAIL rx_rst_idx: got %0d need 0", received_index); end
      if (received_arg !== 32'd0)  begin errors++; $display("FAIL rx_rst_arg: got %h need 0", received_arg); end
      if (cmd_valid !== 1'b0 || crc_error !== 1'b0) begin errors++; $display("FAIL rx_rst_pulse: got v=%b e=%b need 0/0", cmd_valid, crc_error); end

      // Valid frame, then reset while response bit 10 is on the line.
      response_status = 32'h1234_5678;
      @(negedge CLK_SD_card);
      send_frame(f);
      ew = mk_frame({2'b00, 6'd17, 32'h1234_5678});
      @(negedge CLK_SD_card);
      checks++;
      if (cmd_valid !== 1'b1 || received_index !== 6'd17) begin errors++; $display("FAIL tx_pre_valid: got v=%b idx=%0d need 1/17", cmd_valid, received_index); end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK_SD_card);
         ok = (cmd_from_sd_oe === 1'b1);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL tx_pre_oe: got no oe rise need one"); end
      repeat (37) @(negedge CLK_SD_card);
      reset = 1'b0;
      @(negedge CLK_SD_card);
      reset = 1'b1;
      checks += 3;
      if (cmd_from_sd !== 1'b1 || cmd_from_sd_oe !== 1'b0) begin errors++; $display("FAIL tx_rst_line: got cmd=%b oe=%b need 1/0", cmd_from_sd, cmd_from_sd_oe); end
      if (received_index !== 6'd0 || received_arg !== 32'd0) begin errors++; $display("FAIL tx_rst_regs: got idx=%0d arg=%h need 0/0", received_index, received_arg); end
      if (cmd_valid !== 1'b0 || crc_error !== 1'b0) begin errors++; $display("FAIL tx_rst_pulse: got v=%b e=%b need 0/0", cmd_valid, crc_error); end
      wait_rsp(ok);
      if (ok) begin
         w = got_word.pop_front(); l = got_len.pop_front(); r = got_rise.pop_front();
         checks += 2;
         if (l != 38) begin errors++; $display("FAIL tx_rst_len: got %0d bits need 38", l); end
         if (w[37:0] !== ew[47:10]) begin errors++; $display("FAIL tx_rst_bits: got %h need %h", w[37:0], ew[47:10]); end
      end

      // Normal operation afterwards.
      response_status = 32'h0000_0B00;
      @(negedge CLK_SD_card);
      send_frame(f);
      exp_word.push_back(mk_frame({2'b00, 6'd17, 32'h0000_0B00}));
      exp_rise.push_back(c0 + 1 + NCR);
      @(negedge CLK_SD_card);
      checks++;
      if (cmd_valid !== 1'b1 || received_index !== 6'd17) begin errors++; $display("FAIL post_valid: got v=%b idx=%0d need 1/17", cmd_valid, received_index); end
      wait_rsp(ok);
      ew = exp_word.pop_front();
      er = exp_rise.pop_front();
      if (ok) begin
         w = got_word.pop_front(); l = got_len.pop_front(); r = got_rise.pop_front();
         checks += 3;
         if (w !== ew) begin errors++; $display("FAIL post_rsp: got %h need %h", w, ew); end
         if (l != 48)  begin errors++; $display("FAIL post_len: got %0d need 48", l); end
         if (r != er)  begin errors++; $display("FAIL post_lat: oe rose at %0d need %0d", r, er); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [47:0] f2, w, ew;
      int l, r, er, v0;
      f2 = mk_frame({8'h51, 32'h0000_1000});
      v0 = n_valid;
      response_status = 32'h0000_0A00;
      @(negedge CLK_SD_card);
      send_frame(48'h51_0000_0000_55);
      exp_word.push_back(mk_frame({2'b00, 6'd17, 32'h0000_0A00}));
      exp_rise.push_back(c0 + 1 + NCR);
      @(negedge CLK_SD_card);
      checks++;
      if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b need 1", cmd_valid); end
      cmd_to_sd = 1'b0;  // stray start bit while waiting to respond
      @(negedge CLK_SD_card);
      cmd_to_sd = 1'b1;
      @(negedge CLK_SD_card);
      response_status = 32'h8000_0100;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge CLK_SD_card);
         ok = (cmd_from_sd_oe === 1'b0);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_oe_fall: got oe stuck high need fall"); end
      send_frame(f2);
      exp_word.push_back(mk_frame({2'b00, 6'd17, 32'h8000_0100}));
      exp_rise.push_back(c0 + 1 + NCR);
      @(negedge CLK_SD_card);
      checks += 2;
      if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b need 1", cmd_valid); end
      if (received_arg !== 32'h0000_1000) begin errors++; $display("FAIL b2b_arg2: got %h need 00001000", received_arg); end
      for (int k = 0; k < 2; k++) begin
         if (got_word.size() == 0) wait_rsp(ok);
         else ok = 1'b1;
         ew = exp_word.pop_front();
         er = exp_rise.pop_front();
         if (ok) begin
            w = got_word.pop_front(); l = got_len.pop_front(); r = got_rise.pop_front();
            checks += 3;
            if (w !== ew) begin errors++; $display("FAIL b2b_rsp%0d: got %h need %h", k, w, ew); end
            if (l != 48)  begin errors++; $display("FAIL b2b_len%0d: got %0d need 48", k, l); end
            if (r != er)  begin errors++; $display("FAIL b2b_lat%0d: oe rose at %0d need %0d", k, r, er); end
         end
      end
      checks++;
      if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_count: got %0d pulses need 2", n_valid - v0); end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd17();
      test_crc_error();
      test_bad_bits();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 time units, need finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sd_cmd_responder.md
# sd_cmd_responder

Card-side endpoint of the SD CMD line. It deserializes 48-bit command frames driven by the host `CMD` block and validates them. Valid commands are presented in parallel to the card model, and the block then serializes a 48-bit R1-style response back to the host. It sits in the SD-card model and verification environment, opposite the host `CMD` block, and replaces the ad-hoc parallel/serial helpers used in benches.

## Interface
Parameters:
- `NCR`, default 2: idle cycles between the command end bit and the response start bit. Legal range 1..64.

Ports:
- `CLK_SD_card`, in, 1: SD card clock. Single clock domain; everything samples and launches on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `cmd_to_sd`, in, 1: serial command line from the host. Idles high.
- `response_status`, in, 32: card status to return in the response.
- `cmd_from_sd`, out, 1: serial response line to the host. Idles high.
- `cmd_from_sd_oe`, out, 1: high while the response is driven.
- `received_index`, out, 6: index of the last valid command.
- `received_arg`, out, 32: argument of the last valid command.
- `cmd_valid`, out, 1: one-cycle pulse when a valid frame has been accepted.
- `crc_error`, out, 1: one-cycle pulse when a frame is rejected.

## Operation
Command frame, MSB first, bits 47..0:
- start bit = 0
- transmission bit = 1
- index[5:0]
- arg[31:0]
- CRC7
- end bit = 1

CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over bits 47..8.

State machine:
- **IDLE**: `cmd_to_sd` sampled 0 → RECEIVE, with that sample taken as bit 47.
- **RECEIVE**: shift in 47 more bits, counted by a 6-bit counter. After the end bit is sampled → CHECK.
- **CHECK** (1 cycle). The frame is valid only if transmission bit = 1, end bit = 1 and CRC7 matches.
  - Valid: `cmd_valid` = 1, latch `received_index` and `received_arg`. Go to WAIT if index ≠ 0, otherwise IDLE (CMD0 gets no response).
  - Invalid: `crc_error` = 1, outputs unchanged, → IDLE. No response is sent.
- **WAIT**: count `NCR` cycles with the line released → SEND.
- **SEND**: on entry, latch `response_status`. Drive 48 bits:
  - 0, 0
  - `received_index`
  - latched status
  - CRC7 over the first 40 response bits
  - 1
  - Then → IDLE.
- `cmd_to_sd` is ignored in CHECK, WAIT and SEND. A start bit arriving during those states is lost; this is not an error.
- `reset` low at any rising edge, in any state:
  - next state IDLE
  - `cmd_from_sd` = 1, `cmd_from_sd_oe` = 0
  - `received_index` = 0, `received_arg` = 0
  - `cmd_valid` = 0, `crc_error` = 0
  - shift register and counters cleared
  - An in-flight frame or response is abandoned.

## Timing
- Reset values: `cmd_from_sd` = 1, `cmd_from_sd_oe` = 0, all other outputs 0.
- All outputs are registered.
- Let edge E0 sample the end bit.
  - E0+1: `cmd_valid` or `crc_error` rises for exactly one cycle. `received_*` update on the same edge.
  - E0+1+NCR: `cmd_from_sd_oe` rises and `cmd_from_sd` = 0 (response start bit).
  - Each response bit is held one cycle. Bit 0 (end bit = 1) is driven in cycle E0+NCR+48.
  - E0+1+NCR+48: `cmd_from_sd_oe` falls and `cmd_from_sd` = 1.
- Earliest next command start bit is sampled at E0+2+NCR+48. Back-to-back frames are accepted with zero gap after `oe` falls.
- If CMD0 or an invalid frame ends at E0, the next start bit may be sampled at E0+2.
- `response_status` is sampled exactly once, at the edge entering SEND. Changes after that edge do not affect the frame in flight.

## Test plan
- CMD0 frame 0x40_0000_0000_95 → `cmd_valid` pulse at E0+1, `received_index` = 0, `received_arg` = 0, `oe` stays 0 throughout.
- CMD17 frame 0x51_0000_0000_55 with `response_status` = 0x0000_0900 and NCR = 2 → `oe` rises at E0+3 and stays high 48 cycles. Captured response bits 47..8 = 0x11_0000_0900; CRC7 matches the bench model; end bit 1.
- CMD8 frame 0x48_0000_01AA_87 with one CRC bit flipped → `crc_error` pulse, `cmd_valid` = 0, `received_arg` keeps its prior value, no response.
- CMD8 frame with transmission bit = 0 (0x08_0000_01AA_xx) or end bit = 0 → `crc_error` pulse, no response.
- `reset` asserted low for one cycle mid-RECEIVE (bit 20) and again mid-SEND (bit 10) → next cycle `oe` = 0, `cmd_from_sd` = 1, all outputs 0. A following valid CMD17 is then accepted normally.
- Two CMD17 frames, the second starting on the first cycle after `oe` falls → both `cmd_valid` pulses occur and both responses are complete. A start bit injected during WAIT is ignored.
